imm_ext_pipe: RTL and testbench
===============================

Name: imm_ext_pipe

Overview:
Parametrised immediate-extension stage for the decode pipeline. It takes an IN_W-bit instruction immediate plus a mode, and produces an OUT_W-bit operand.
- Supported modes: sign-extend, zero-extend, upper-load placement, and branch-offset (sign-extend then shift left 2).
- Registered output with a valid/ready handshake.
- 2-entry skid buffer, so in_ready is a pure register output.
- Sits between instruction fetch/decode and the operand-select mux feeding the ALU.

Parameters:
- IN_W, 16, immediate width.
- OUT_W, 32, extended operand width; must satisfy OUT_W > IN_W + 2.
- TAG_W, 5, width of the sideband tag (destination register index) carried with each item.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  synchronous pipeline flush; drops all buffered items.
- in_valid  in  1  upstream item valid.
- in_ready  out  1  stage can accept an item; registered.
- in_imm  in  IN_W  raw immediate.
- in_mode  in  2  extension mode (encodings under Behaviour).
- in_tag  in  TAG_W  sideband tag.
- out_valid  out  1  out_data/out_tag valid.
- out_ready  in  1  downstream accepts.
- out_data  out  OUT_W  extended operand.
- out_tag  out  TAG_W  tag of the item on out_data.

Behaviour:
- Modes (combinational, computed on input before registering):
  - SIGN=2'b00: replicate in_imm[IN_W-1] into upper OUT_W-IN_W bits. The sign is decided by the MSB only; 0x8000 is negative.
  - ZERO=2'b01: upper bits 0.
  - UPPER=2'b10: {in_imm, (OUT_W-IN_W) zeros}.
  - BRANCH=2'b11: SIGN result shifted left 2; low 2 bits 0; top 2 bits discarded.
- Handshake:
  - Input transfer when in_valid && in_ready.
  - Output transfer when out_valid && out_ready.
  - out_data/out_tag hold stable while out_valid && !out_ready.
- Storage: main register (drives outputs) and skid register, each with its own valid bit.
- Per cycle, with accept = in_valid && in_ready and pop = out_valid && out_ready:
  - Main empty, or pop: main loads the skid entry if skid is valid, else the incoming item if accept, else main becomes empty.
  - Main full and not pop, with accept: incoming item goes to skid.
  - Skid emptied whenever its entry moves to main.
- in_ready (registered) = !skid_valid_next. An item is never accepted when both entries are full.
- Latency: 1 cycle from input accept to out_valid when the stage is empty. Throughput: 1 item/cycle under continuous out_ready.
- Ordering: strict FIFO; the skid entry always precedes a new arrival.
- Simultaneous pop and accept with skid full is impossible, since in_ready=0.
- Simultaneous pop and accept with main full and skid empty: the new item goes to main; skid stays empty.
- flush: next cycle both valid bits are 0 and in_ready=1. An item presented in the flush cycle is discarded. flush has priority over all transfers.
- reset (also mid-transfer): out_valid=0, in_ready=1, out_data=0, out_tag=0, both valid bits 0. reset has priority over flush.
- Data registers load only on transfer, not when idle; no X propagation after reset.

Decomposition:
- Shared package imm_ext_pkg:
  - mode localparams MODE_SIGN, MODE_ZERO, MODE_UPPER, MODE_BRANCH;
  - 2-bit mode typedef.
- Sub-module imm_ext_comb: pure combinational extender (IN_W, OUT_W, mode -> data). It is reused by the jump/address unit.
- imm_ext_pipe instantiates imm_ext_comb once on the input side and holds the skid buffer logic.

Test Plan:
- Mode sweep, out_ready=1, IN_W=16/OUT_W=32:
  - SIGN 0x8000 -> 0xFFFF8000;
  - SIGN 0x7FFF -> 0x00007FFF;
  - ZERO 0x8000 -> 0x00008000;
  - UPPER 0x1234 -> 0x12340000;
  - BRANCH 0xFFFF -> 0xFFFFFFFC;
  - each valid 1 cycle after accept, tag preserved.
- Backpressure: hold out_ready=0 and send items A, B -> in_ready drops after B; out_data stays A. Release out_ready -> A then B on consecutive cycles, in_ready returns 1.
- Streaming: 100 random items with out_ready=1 continuously -> one output per cycle, order and tags match a reference model.
- Random out_ready/in_valid toggling for 10k cycles -> no loss, no duplication, out_data stable while stalled.
- Flush with both entries full and in_valid=1 -> next cycle out_valid=0, in_ready=1, no stale item ever emitted.
- Reset asserted mid-stall with both entries full -> next cycle out_valid=0, in_ready=1, out_data=0. First post-reset item has latency 1.

Source files
------------

// File: rtl/imm_ext_pkg.sv
// Shared definitions for the immediate-extension logic: the mode encoding used
// by the decode pipeline stage and by the jump/address unit.
package imm_ext_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_SIGN   = 2'b00;
  localparam mode_t MODE_ZERO   = 2'b01;
  localparam mode_t MODE_UPPER  = 2'b10;
  localparam mode_t MODE_BRANCH = 2'b11;

endpackage

// File: rtl/imm_ext_comb.sv
// Purely combinational immediate extender. Turns an IN_W-bit immediate into an
// OUT_W-bit operand according to the extension mode. OUT_W must exceed IN_W+2
// so the branch shift always has sign bits to discard.
module imm_ext_comb
  import imm_ext_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
) (
  input  logic [1:0]       mode,
  input  logic [IN_W-1:0]  imm,
  output logic [OUT_W-1:0] data
);

  logic [OUT_W-1:0] sext;

  assign sext = {{(OUT_W-IN_W){imm[IN_W-1]}}, imm};

  // Select the extension; branch offsets are word offsets, so shift left by 2
  // and drop the top two sign bits.
  always_comb begin
    data = sext;
    case (mode)
      MODE_SIGN:   data = sext;
      MODE_ZERO:   data = {{(OUT_W-IN_W){1'b0}}, imm};
      MODE_UPPER:  data = {imm, {(OUT_W-IN_W){1'b0}}};
      MODE_BRANCH: data = {sext[OUT_W-3:0], 2'b00};
      default:     data = sext;
    endcase
  end

endmodule

// File: rtl/imm_ext_pipe.sv
// Registered immediate-extension stage with a 2-entry skid buffer. The
// extension is done on the input side, so both storage entries hold finished
// operands. in_ready comes straight from a flop to keep upstream timing short.
module imm_ext_pipe
  import imm_ext_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_imm,
  input  logic [1:0]       in_mode,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [TAG_W-1:0] out_tag
);

  logic [OUT_W-1:0] ext_data;

  logic             main_valid;
  logic [OUT_W-1:0] main_data;
  logic [TAG_W-1:0] main_tag;
  logic             skid_valid;
  logic [OUT_W-1:0] skid_data;
  logic [TAG_W-1:0] skid_tag;
  logic             in_ready_q;

  logic accept;
  logic pop;
  logic main_load_skid;
  logic main_load_in;
  logic skid_load;
  logic main_valid_nx;
  logic skid_valid_nx;

  imm_ext_comb #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) u_ext (
    .mode (in_mode),
    .imm  (in_imm),
    .data (ext_data)
  );

  // Decide where each item moves this cycle. The skid entry is older than any
  // new arrival, so it always refills main first; in_ready is low whenever the
  // skid is occupied, so a skid move and an accept never coincide.
  always_comb begin
    accept         = in_valid && in_ready_q;
    pop            = main_valid && out_ready;
    main_load_skid = 1'b0;
    main_load_in   = 1'b0;
    skid_load      = 1'b0;
    main_valid_nx  = main_valid;
    skid_valid_nx  = skid_valid;
    if (!main_valid || pop) begin
      if (skid_valid) begin
        main_load_skid = 1'b1;
        main_valid_nx  = 1'b1;
        skid_valid_nx  = 1'b0;
      end else if (accept) begin
        main_load_in  = 1'b1;
        main_valid_nx = 1'b1;
      end else begin
        main_valid_nx = 1'b0;
      end
    end else if (accept) begin
      skid_load     = 1'b1;
      skid_valid_nx = 1'b1;
    end
  end

  // Occupancy and ready flags; reset beats flush, and flush beats any transfer.
  always_ff @(posedge clk) begin
    if (reset) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      in_ready_q <= 1'b1;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      in_ready_q <= 1'b1;
    end else begin
      main_valid <= main_valid_nx;
      skid_valid <= skid_valid_nx;
      in_ready_q <= !skid_valid_nx;
    end
  end

  // Payload registers only change on a transfer so outputs stay stable while
  // stalled; reset clears them so nothing undefined ever reaches the outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      main_data <= '0;
      main_tag  <= '0;
      skid_data <= '0;
      skid_tag  <= '0;
    end else if (!flush) begin
      if (main_load_skid) begin
        main_data <= skid_data;
        main_tag  <= skid_tag;
      end else if (main_load_in) begin
        main_data <= ext_data;
        main_tag  <= in_tag;
      end
      if (skid_load) begin
        skid_data <= ext_data;
        skid_tag  <= in_tag;
      end
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = main_valid;
  assign out_data  = main_data;
  assign out_tag   = main_tag;

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Self-checking bench for imm_ext_pipe: directed mode/backpressure/flush/reset
// scenarios followed by random traffic, all checked by a scoreboard monitor.
module tb_imm_ext_pipe;

  localparam int IN_W  = 16;
  localparam int OUT_W = 32;
  localparam int TAG_W = 5;

  typedef struct packed {
    logic [OUT_W-1:0] data;
    logic [TAG_W-1:0] tag;
  } item_t;

  logic             clk;
  logic             reset;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_imm;
  logic [1:0]       in_mode;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic [TAG_W-1:0] out_tag;

  item_t sbq[$];
  int    tests = 0;
  int    fails = 0;

  imm_ext_pipe #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W),
    .TAG_W (TAG_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_imm    (in_imm),
    .in_mode   (in_mode),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_tag   (out_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference extension from arithmetic on the immediate's numeric value.
  function automatic logic [OUT_W-1:0] refExtend(input int mode, input longint imm);
    longint sval;
    longint v;
    sval = (imm >= (64'sd1 <<< (IN_W-1))) ? imm - (64'sd1 <<< IN_W) : imm;
    case (mode)
      0:       v = sval;
      1:       v = imm;
      2:       v = imm * (64'sd1 <<< (OUT_W-IN_W));
      default: v = sval * 4;
    endcase
    return v[OUT_W-1:0];
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Drives one cycle of inputs (called at posedge+1), records whether the item
  // is accepted, and returns at posedge+1 of the following cycle.
  task automatic applyStimulus(input logic v, input logic [IN_W-1:0] imm, input logic [1:0] mode,
                               input logic [TAG_W-1:0] tag, input logic ordy, input logic fl,
                               input logic rst);
    logic  acc;
    item_t it;
    in_valid  = v;
    in_imm    = imm;
    in_mode   = mode;
    in_tag    = tag;
    out_ready = ordy;
    flush     = fl;
    reset     = rst;
    @(negedge clk);
    acc     = in_valid && in_ready && !flush && !reset;
    it.data = refExtend(int'(mode), longint'(imm));
    it.tag  = tag;
    @(posedge clk);
    #1;
    if (acc) sbq.push_back(it);
  endtask

  // Monitor: the queue mirrors the stage contents, so the head must match the
  // output whenever it is valid, and occupancy decides valid/ready.
  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      if (sbq.size() == 0) begin
        tests++;
        fails++;
        $display("[TB] FAIL spurious_out: got data 0x%0h tag %0d, expected no valid output", out_data, out_tag);
      end else begin
        checkOutput("out_data", 64'(out_data), 64'(sbq[0].data));
        checkOutput("out_tag", 64'(out_tag), 64'(sbq[0].tag));
      end
    end
    checkOutput("out_valid", 64'(out_valid), 64'(sbq.size() > 0));
    checkOutput("in_ready", 64'(in_ready), 64'(sbq.size() < 2));
    if (reset || flush) sbq.delete();
    else if (out_valid && out_ready && sbq.size() > 0) void'(sbq.pop_front());
  end

  logic [IN_W-1:0]  sweep_imm [5];
  logic [1:0]       sweep_mode[5];
  logic [OUT_W-1:0] sweep_exp [5];

  initial begin
    in_valid  = 1'b0;
    in_imm    = '0;
    in_mode   = 2'b00;
    in_tag    = '0;
    out_ready = 1'b0;
    flush     = 1'b0;
    reset     = 1'b1;
    @(posedge clk);
    #1;
    applyStimulus(1'b0, '0, 2'b00, '0, 1'b0, 1'b0, 1'b1);
    checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
    checkOutput("reset_in_ready", 64'(in_ready), 64'd1);
    checkOutput("reset_out_data", 64'(out_data), 64'd0);
    checkOutput("reset_out_tag", 64'(out_tag), 64'd0);
    applyStimulus(1'b0, '0, 2'b00, '0, 1'b1, 1'b0, 1'b0);

    // Mode sweep with known answers, latency 1, tag preserved.
    sweep_imm[0] = 16'h8000; sweep_mode[0] = 2'b00; sweep_exp[0] = 32'hFFFF8000;
    sweep_imm[1] = 16'h7FFF; sweep_mode[1] = 2'b00; sweep_exp[1] = 32'h00007FFF;
    sweep_imm[2] = 16'h8000; sweep_mode[2] = 2'b01; sweep_exp[2] = 32'h00008000;
    sweep_imm[3] = 16'h1234; sweep_mode[3] = 2'b10; sweep_exp[3] = 32'h12340000;
    sweep_imm[4] = 16'hFFFF; sweep_mode[4] = 2'b11; sweep_exp[4] = 32'hFFFFFFFC;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, sweep_imm[i], sweep_mode[i], TAG_W'(i + 3), 1'b1, 1'b0, 1'b0);
      checkOutput("sweep_valid", 64'(out_valid), 64'd1);
      checkOutput("sweep_data", 64'(out_data), 64'(sweep_exp[i]));
      checkOutput("sweep_tag", 64'(out_tag), 64'(i + 3));
    end
    applyStimulus(1'b0, '0, 2'b00, '0, 1'b1, 1'b0, 1'b0);

    // Backpressure: A then B with out_ready low fills both entries.
    applyStimulus(1'b1, 16'h00AA, 2'b01, 5'd10, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'h00BB, 2'b01, 5'd11, 1'b0, 1'b0, 1'b0);
    checkOutput("bp_in_ready_low", 64'(in_ready), 64'd0);
    checkOutput("bp_hold_a", 64'(out_data), 64'h00AA);
    applyStimulus(1'b1, 16'h00CC, 2'b01, 5'd12, 1'b0, 1'b0, 1'b0);
    checkOutput("bp_still_a", 64'(out_data), 64'h00AA);
    applyStimulus(1'b0, '0, 2'b00, '0, 1'b1, 1'b0, 1'b0);
    checkOutput("bp_b_next", 64'(out_data), 64'h00BB);
    checkOutput("bp_in_ready_back", 64'(in_ready), 64'd1);
    applyStimulus(1'b0, '0, 2'b00, '0, 1'b1, 1'b0, 1'b0);
    checkOutput("bp_drained", 64'(out_valid), 64'd0);

    // Streaming: continuous traffic, one result per cycle.
    for (int i = 0; i < 100; i++)
      applyStimulus(1'b1, IN_W'($urandom), 2'($urandom_range(0, 3)), TAG_W'($urandom), 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, 2'b00, '0, 1'b1, 1'b0, 1'b0);

    // Flush with both entries full and a new item offered.
    applyStimulus(1'b1, 16'h1111, 2'b00, 5'd1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'h2222, 2'b00, 5'd2, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'h3333, 2'b00, 5'd3, 1'b0, 1'b1, 1'b0);
    checkOutput("flush_out_valid", 64'(out_valid), 64'd0);
    checkOutput("flush_in_ready", 64'(in_ready), 64'd1);
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b0, '0, 2'b00, '0, 1'b1, 1'b0, 1'b0);

    // Reset in the middle of a full stall.
    applyStimulus(1'b1, 16'h4444, 2'b10, 5'd4, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'h5555, 2'b10, 5'd5, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'h6666, 2'b10, 5'd6, 1'b0, 1'b0, 1'b1);
    checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_in_ready", 64'(in_ready), 64'd1);
    checkOutput("rst_out_data", 64'(out_data), 64'd0);
    checkOutput("rst_out_tag", 64'(out_tag), 64'd0);
    applyStimulus(1'b1, 16'hFFFE, 2'b11, 5'd7, 1'b0, 1'b0, 1'b0);
    checkOutput("post_rst_latency", 64'(out_valid), 64'd1);
    checkOutput("post_rst_data", 64'(out_data), 64'hFFFFFFF8);
    applyStimulus(1'b0, '0, 2'b00, '0, 1'b1, 1'b0, 1'b0);

    // Random handshake toggling with occasional flushes.
    for (int i = 0; i < 10000; i++)
      applyStimulus(1'($urandom_range(0, 1)), IN_W'($urandom), 2'($urandom_range(0, 3)),
                    TAG_W'($urandom), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 199) == 0), 1'b0);

    for (int i = 0; i < 4; i++)
      applyStimulus(1'b0, '0, 2'b00, '0, 1'b1, 1'b0, 1'b0);
    checkOutput("drain_empty", 64'(sbq.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
